// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding for the decode stage and the control FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_FWD = 3'b000,  // RESULT = DATA2
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SUB = 3'b100,  // DATA1 - DATA2
    OP_MUL = 3'b101,  // unsigned, multi-cycle
    OP_SLL = 3'b110,
    OP_SRA = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per cycle.
// Ports:
//   CLK, RESET   - clock, synchronous active-high reset
//   start        - load a/b and begin (ignored while busy)
//   a, b         - WIDTH-bit operands
//   busy         - iterating (WIDTH cycles after start)
//   done         - high during the final iteration cycle
//   product      - 2*WIDTH-bit product, valid while done is high
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_next;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // done/product look at the accumulation happening this cycle, so the
  // parent can register the final product on the same edge that ends the
  // last iteration instead of one cycle later.
  assign done    = busy && (cnt_q == '0);
  assign product = acc_next;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy     <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start && !busy) begin
      busy     <= 1'b1;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= CW'(WIDTH - 1);
    end else if (busy) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
      if (cnt_q == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle FWD/ADD/AND/OR/SUB/SLL/SRA, WIDTH-cycle MUL.
// Ports:
//   CLK, RESET             - clock, synchronous active-high reset
//   START, OPCODE          - request and operation select (accepted in IDLE/DONE)
//   DATA1, DATA2           - operands (DATA2 low bits = shift amount)
//   BUSY                   - MUL in progress
//   DONE                   - one-cycle completion pulse
//   RESULT, HI             - registered result; HI = MUL upper half, else 0
//   ZERO, CARRY, OVERFLOW  - registered flags
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] HI,
  output logic             ZERO,
  output logic             CARRY,
  output logic             OVERFLOW
);

  localparam int SW = $clog2(WIDTH);

  state_e  state_q, state_d;
  opcode_e op;
  logic    accept, mul_start;

  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   add_w;
  logic [WIDTH-1:0] sub_w;
  logic [SW-1:0]    sh;

  assign op        = opcode_e'(OPCODE);
  assign accept    = START && (state_q != S_MUL);
  assign mul_start = accept && (op == OP_MUL);
  assign BUSY      = (state_q == S_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (mul_start),
    .a       (DATA1),
    .b       (DATA2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle datapath, evaluated on the live inputs and captured on the
  // accepting edge; nothing downstream looks at the inputs again.
  always_comb begin
    add_w   = {1'b0, DATA1} + {1'b0, DATA2};
    sub_w   = DATA1 - DATA2;
    sh      = DATA2[SW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_FWD: alu_res = DATA2;
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) &&
                  (add_w[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_AND: alu_res = DATA1 & DATA2;
      OP_OR:  alu_res = DATA1 | DATA2;
      OP_SUB: begin
        alu_res = sub_w;
        alu_c   = (DATA1 >= DATA2);  // not-borrow
        alu_v   = (DATA1[WIDTH-1] != DATA2[WIDTH-1]) &&
                  (sub_w[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_SLL: alu_res = DATA1 << sh;
      OP_SRA: alu_res = WIDTH'($signed(DATA1) >>> sh);
      default: alu_res = '0;  // OP_MUL handled by the sequencer
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START)                state_d = (op == OP_MUL) ? S_MUL : S_DONE;
        else if (state_q == S_DONE) state_d = S_IDLE;
      end
      S_MUL:   if (mul_done) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      DONE     <= 1'b0;
      RESULT   <= '0;
      HI       <= '0;
      ZERO     <= 1'b0;
      CARRY    <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (accept && op != OP_MUL) begin
        DONE     <= 1'b1;
        RESULT   <= alu_res;
        HI       <= '0;
        ZERO     <= (alu_res == '0);
        CARRY    <= alu_c;
        OVERFLOW <= alu_v;
      end else if (state_q == S_MUL && mul_done) begin
        DONE     <= 1'b1;
        RESULT   <= mul_prod[WIDTH-1:0];
        HI       <= mul_prod[2*WIDTH-1:WIDTH];
        ZERO     <= (mul_prod[WIDTH-1:0] == '0);
        CARRY    <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
        OVERFLOW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=8): expected completions are queued when
// an op is issued and popped by a negedge monitor on each DONE pulse.
module tb_alu_mc;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET, START;
  logic [2:0]   OPCODE;
  logic [W-1:0] DATA1, DATA2;
  logic         BUSY, DONE, ZERO, CARRY, OVERFLOW;
  logic [W-1:0] RESULT, HI;

  typedef struct {
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         zero, carry, ov;
  } exp_t;

  exp_t scb[$];
  int   n_cmp = 0, n_bad = 0, done_cnt = 0;

  always #5 CLK = ~CLK;

  alu_mc #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE),
    .DATA1(DATA1), .DATA2(DATA2), .BUSY(BUSY), .DONE(DONE),
    .RESULT(RESULT), .HI(HI), .ZERO(ZERO), .CARRY(CARRY), .OVERFLOW(OVERFLOW)
  );

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ia, ib, sa, sbv, r, sr, sh;
    ia = a; ib = b; sa = $signed(a); sbv = $signed(b); sh = ib % W;
    e.hi = '0; e.carry = 1'b0; e.ov = 1'b0; r = 0;
    case (op)
      3'd0: r = ib;
      3'd1: begin r = ia + ib; e.carry = (r > 255); sr = sa + sbv; e.ov = (sr > 127 || sr < -128); end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: begin r = ia - ib; e.carry = (ia >= ib); sr = sa - sbv; e.ov = (sr > 127 || sr < -128); end
      3'd5: begin r = ia * ib; e.hi = r[15:8]; e.carry = (r[15:8] != 0); end
      3'd6: r = ia << sh;
      default: r = sa >>> sh;
    endcase
    e.result = r[7:0];
    e.zero   = (e.result == 0);
    return e;
  endfunction

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (!RESET && DONE) begin
      done_cnt++;
      n_cmp++;
      if (scb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_done: got DONE with result %h, required no completion", RESULT);
      end else begin
        exp_t e;
        e = scb.pop_front();
        if (RESULT !== e.result || HI !== e.hi || ZERO !== e.zero ||
            CARRY !== e.carry || OVERFLOW !== e.ov) begin
          n_bad++;
          $display("FAIL sb_result: got r=%h hi=%h z=%b c=%b v=%b, required r=%h hi=%h z=%b c=%b v=%b",
                   RESULT, HI, ZERO, CARRY, OVERFLOW, e.result, e.hi, e.zero, e.carry, e.ov);
        end
      end
    end
  end

  // Issue one op for one cycle, then scramble the inputs so late changes
  // would show up if the DUT failed to latch.
  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    @(negedge CLK);
    START = 1'b1; OPCODE = op; DATA1 = a; DATA2 = b;
    if (push) scb.push_back(model(op, a, b));
    @(negedge CLK);
    START = 1'b0; OPCODE = 3'($urandom); DATA1 = W'($urandom); DATA2 = W'($urandom);
  endtask

  task automatic test_reset;
    RESET = 1'b1; START = 1'b1; OPCODE = 3'd1; DATA1 = 8'd1; DATA2 = 8'd1;
    repeat (3) @(negedge CLK);
    #1;
    n_cmp++;
    if ({BUSY, DONE, RESULT, HI, ZERO, CARRY, OVERFLOW} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b r=%h hi=%h z=%b c=%b v=%b, required all 0",
               BUSY, DONE, RESULT, HI, ZERO, CARRY, OVERFLOW);
    end
    @(negedge CLK);
    RESET = 1'b0; START = 1'b0;
    @(negedge CLK); #1;
    n_cmp++;
    if (DONE !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_dominates_start: got DONE=%b, required 0", DONE);
    end
  endtask

  task automatic test_add;
    drive(3'd1, 8'd3, 8'd4, 1); #1;
    n_cmp++;
    if (DONE !== 1'b1 || RESULT !== 8'd7 || ZERO !== 1'b0 || CARRY !== 1'b0 || OVERFLOW !== 1'b0) begin
      n_bad++;
      $display("FAIL add_3_4: got done=%b r=%0d z=%b c=%b v=%b, required done=1 r=7 z=0 c=0 v=0",
               DONE, RESULT, ZERO, CARRY, OVERFLOW);
    end
    drive(3'd1, 8'd200, 8'd100, 1); #1;
    n_cmp++;
    if (RESULT !== 8'd44 || CARRY !== 1'b1) begin
      n_bad++;
      $display("FAIL add_carry: got r=%0d c=%b, required r=44 c=1", RESULT, CARRY);
    end
    drive(3'd1, 8'd127, 8'd1, 1); #1;
    n_cmp++;
    if (RESULT !== 8'd128 || OVERFLOW !== 1'b1) begin
      n_bad++;
      $display("FAIL add_overflow: got r=%0d v=%b, required r=128 v=1", RESULT, OVERFLOW);
    end
  endtask

  task automatic test_sub;
    drive(3'd4, 8'd3, 8'd4, 1); #1;
    n_cmp++;
    if (RESULT !== 8'hFF || CARRY !== 1'b0 || OVERFLOW !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_3_4: got r=%h c=%b v=%b, required r=ff c=0 v=0", RESULT, CARRY, OVERFLOW);
    end
    drive(3'd4, 8'd5, 8'd5, 1); #1;
    n_cmp++;
    if (RESULT !== 8'd0 || ZERO !== 1'b1 || CARRY !== 1'b1) begin
      n_bad++;
      $display("FAIL sub_5_5: got r=%h z=%b c=%b, required r=0 z=1 c=1", RESULT, ZERO, CARRY);
    end
    drive(3'd4, 8'h80, 8'h01, 1);  // signed overflow on SUB
    @(negedge CLK);
  endtask

  task automatic test_logic_fwd;
    drive(3'd0, 8'h11, 8'hA5, 1);
    drive(3'd2, 8'hF0, 8'h3C, 1);
    drive(3'd3, 8'hF0, 8'h0C, 1);
    for (int i = 0; i < 8; i++) drive(3'($urandom_range(0, 7) & 3'b011), W'($urandom), W'($urandom), 1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_shift;
    drive(3'd6, 8'h81, 8'd1, 1); #1;
    n_cmp++;
    if (RESULT !== 8'h02) begin
      n_bad++;
      $display("FAIL sll_81_1: got %h, required 02", RESULT);
    end
    drive(3'd7, 8'h80, 8'd3, 1); #1;
    n_cmp++;
    if (RESULT !== 8'hF0) begin
      n_bad++;
      $display("FAIL sra_80_3: got %h, required f0", RESULT);
    end
    drive(3'd7, 8'h80, 8'h0B, 1); #1;
    n_cmp++;
    if (RESULT !== 8'hF0) begin
      n_bad++;
      $display("FAIL sra_amount_mask: got %h, required f0", RESULT);
    end
    drive(3'd6, 8'h5A, 8'hFF, 1);
    @(negedge CLK);
  endtask

  task automatic test_mul;
    int busy_n, done_at;
    busy_n = 0; done_at = -1;
    drive(3'd5, 8'd200, 8'd200, 1);
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) @(negedge CLK);
      #1;
      if (BUSY) busy_n++;
      if (DONE && done_at < 0) done_at = k;
    end
    n_cmp++;
    if (busy_n != 8 || done_at != 9) begin
      n_bad++;
      $display("FAIL mul_timing: got busy_cycles=%0d done_cycle=%0d, required 8 and 9", busy_n, done_at);
    end
    n_cmp++;
    if (RESULT !== 8'h40 || HI !== 8'h9C || CARRY !== 1'b1) begin
      n_bad++;
      $display("FAIL mul_200_200: got r=%h hi=%h c=%b, required r=40 hi=9c c=1", RESULT, HI, CARRY);
    end
    drive(3'd5, 8'd15, 8'd17, 1);
    repeat (10) @(negedge CLK);
    #1;
    n_cmp++;
    if (RESULT !== 8'hFF || HI !== 8'h00 || CARRY !== 1'b0) begin
      n_bad++;
      $display("FAIL mul_15_17: got r=%h hi=%h c=%b, required r=ff hi=00 c=0", RESULT, HI, CARRY);
    end
  endtask

  task automatic test_start_during_busy;
    int d0;
    d0 = done_cnt;
    drive(3'd5, 8'd3, 8'd3, 1);
    drive(3'd1, 8'd1, 8'd1, 0);  // lands while BUSY, must be dropped
    repeat (14) @(negedge CLK);
    #1;
    n_cmp++;
    if (done_cnt - d0 != 1 || RESULT !== 8'd9) begin
      n_bad++;
      $display("FAIL mul_ignore_start: got done_pulses=%0d r=%0d, required 1 and 9", done_cnt - d0, RESULT);
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_cnt;
    @(negedge CLK);
    START = 1'b1; OPCODE = 3'd1; DATA1 = 8'd10; DATA2 = 8'd20;
    scb.push_back(model(3'd1, 8'd10, 8'd20));
    @(negedge CLK);  // in DONE: issue SUB immediately
    OPCODE = 3'd4; DATA1 = 8'd9; DATA2 = 8'd12;
    scb.push_back(model(3'd4, 8'd9, 8'd12));
    @(negedge CLK);  // in DONE again: issue MUL
    OPCODE = 3'd5; DATA1 = 8'd13; DATA2 = 8'd11;
    scb.push_back(model(3'd5, 8'd13, 8'd11));
    @(negedge CLK);
    START = 1'b0;
    #1;
    n_cmp++;
    if (BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_mul_busy: got BUSY=%b, required 1", BUSY);
    end
    repeat (12) @(negedge CLK);
    #1;
    n_cmp++;
    if (done_cnt - d0 != 3) begin
      n_bad++;
      $display("FAIL b2b_done_count: got %0d pulses, required 3", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_mul;
    int d0;
    d0 = done_cnt;
    drive(3'd5, 8'd7, 8'd9, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    n_cmp++;
    if ({BUSY, DONE, RESULT, HI, ZERO, CARRY, OVERFLOW} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_mul_outputs: got busy=%b done=%b r=%h hi=%h z=%b c=%b v=%b, required all 0",
               BUSY, DONE, RESULT, HI, ZERO, CARRY, OVERFLOW);
    end
    repeat (12) @(negedge CLK);
    #1;
    n_cmp++;
    if (done_cnt != d0) begin
      n_bad++;
      $display("FAIL reset_mid_mul_no_done: got %0d pulses, required 0", done_cnt - d0);
    end
    drive(3'd1, 8'd1, 8'd2, 1); #1;
    n_cmp++;
    if (DONE !== 1'b1 || RESULT !== 8'd3) begin
      n_bad++;
      $display("FAIL add_after_abort: got done=%b r=%0d, required done=1 r=3", DONE, RESULT);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_logic_fwd;
    test_shift;
    test_mul;
    test_start_during_busy;
    test_back_to_back;
    test_reset_mid_mul;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (scb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending completions, required 0", scb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion of all tests");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset, sampled on the rising CLK edge.
REQ-004 SHALL have port START  input  1  request: latch operands and opcode this cycle.
REQ-005 SHALL have port OPCODE  input  3  operation select (encoding in REQ-010).
REQ-006 SHALL have port DATA1  input  WIDTH  first operand.
REQ-007 SHALL have port DATA2  input  WIDTH  second operand; shift amount for shift ops.
REQ-008 SHALL have ports BUSY (output, 1): operation in progress; DONE (output, 1): one-cycle completion pulse; RESULT (output, WIDTH): registered result; HI (output, WIDTH): MUL upper half, else 0; ZERO, CARRY, OVERFLOW (output, 1 each): registered flags.

Function
REQ-009 SHALL implement FSM states IDLE, MUL, DONE; IDLE -> DONE on START with a single-cycle op; IDLE -> MUL on START with MUL; MUL -> DONE after WIDTH iterations; DONE -> IDLE, or DONE -> DONE/MUL when START is asserted in DONE.
REQ-010 SHALL decode OPCODE: 000 FWD (DATA2), 001 ADD, 010 AND, 011 OR, 100 SUB (DATA1-DATA2), 101 MUL (unsigned), 110 SLL (DATA1 << DATA2[$clog2(WIDTH)-1:0]), 111 SRA (arithmetic right shift, same amount).
REQ-011 SHALL accept START only in IDLE or DONE; START while in MUL SHALL be ignored without affecting the operation in progress.
REQ-012 SHALL latch DATA1, DATA2 and OPCODE on the accepting edge; later input changes SHALL NOT affect the result.
REQ-013 Single-cycle ops SHALL have latency 1: RESULT, flags and DONE=1 are valid on the edge after acceptance.
REQ-014 MUL SHALL use shift-add, one bit per cycle; BUSY=1 for WIDTH cycles; DONE=1 exactly WIDTH+1 cycles after acceptance.
REQ-015 MUL SHALL place the low WIDTH bits of the 2*WIDTH-bit product on RESULT and the high WIDTH bits on HI.
REQ-016 DONE SHALL be high for exactly one cycle per accepted operation; RESULT, HI and flags SHALL hold until the next completion.
REQ-017 ZERO SHALL equal (RESULT==0) for every op.
REQ-018 CARRY SHALL be carry-out for ADD, NOT borrow (DATA1>=DATA2) for SUB, (HI!=0) for MUL, and 0 otherwise.
REQ-019 OVERFLOW SHALL be signed two's-complement overflow for ADD/SUB and 0 otherwise.
REQ-020 ADD/SUB SHALL wrap modulo 2^WIDTH.
REQ-021 Shift amounts SHALL use only the low $clog2(WIDTH) bits of DATA2; SRA SHALL replicate DATA1[WIDTH-1].
REQ-022 START in DONE SHALL be accepted (back-to-back); the new op SHALL complete with its normal latency.
REQ-023 BUSY SHALL be 1 only in MUL state.

Reset
REQ-024 RESET SHALL force state IDLE and BUSY, DONE, RESULT, HI, ZERO, CARRY and OVERFLOW to 0 (ZERO is 0 during reset, not 1).
REQ-025 RESET asserted mid-MUL SHALL abort the operation with no DONE pulse.
REQ-026 RESET SHALL dominate START asserted in the same cycle.

Structure
REQ-027 SHALL place the opcode constants/enum (FWD..SRA) and the FSM state enum in package alu_pkg, shared with the decode stage.
REQ-028 SHALL implement the shift-add multiplier as sub-module alu_mul_seq (ports: CLK, RESET, start, a, b, busy, done, product), parameterised by WIDTH.
REQ-029 SHALL keep single-cycle datapath logic combinational, feeding registered outputs.

Verification (WIDTH=8)
REQ-030 ADD 3+4 -> RESULT=7, DONE one cycle after START, ZERO=0, CARRY=0, OVERFLOW=0; ADD 200+100 -> RESULT=44, CARRY=1; ADD 127+1 -> RESULT=128, OVERFLOW=1.
REQ-031 SUB 3-4 -> RESULT=0xFF, CARRY=0, OVERFLOW=0; SUB 5-5 -> RESULT=0, ZERO=1, CARRY=1.
REQ-032 MUL 200*200 -> BUSY for 8 cycles, DONE at cycle 9, RESULT=0x40, HI=0x9C, CARRY=1; MUL 15*17 -> RESULT=0xFF, HI=0, CARRY=0.
REQ-033 START MUL 3*3, then START ADD 1+1 during BUSY -> ADD is ignored; RESULT=9 with a single DONE pulse.
REQ-034 SLL 0x81 by 1 -> 0x02; SRA 0x80 by 3 -> 0xF0; SRA with DATA2=0x0B uses shift amount 3 -> 0xF0.
REQ-035 RESET at cycle 4 of a MUL -> no DONE pulse, all outputs 0, next START ADD 1+2 -> RESULT=3 with latency 1.
